// File: rtl/lc3_regfile_cc_if.sv
// lc3_regfile_cc_if: datapath-side signal bundle for the LC-3 register file /
// condition-code stage. The master (control/datapath) drives selects, strobes
// and the bus; the slave (register file) returns operands and flags.
interface lc3_regfile_cc_if;
  logic [15:0] IR;
  logic [15:0] main_bus;
  logic [1:0]  SR1MUX;
  logic [1:0]  DRMUX;
  logic        LD_REG;
  logic        LD_CC;
  logic        LD_BEN;
  logic [15:0] SR1;
  logic [15:0] SR2;
  logic [2:0]  NZP;
  logic        BEN;

  modport master (
    output IR, main_bus, SR1MUX, DRMUX, LD_REG, LD_CC, LD_BEN,
    input  SR1, SR2, NZP, BEN
  );

  modport slave (
    input  IR, main_bus, SR1MUX, DRMUX, LD_REG, LD_CC, LD_BEN,
    output SR1, SR2, NZP, BEN
  );
endinterface

// File: rtl/lc3_regfile_cc.sv
// lc3_regfile_cc: LC-3 general-purpose registers R0-R7, NZP condition codes
// and the BEN branch-enable flag. Operands SR1/SR2 are combinational reads.
// Optional feature macro: LC3_REGFILE_BYPASS_EN -- when defined, a register
// being written this cycle is forwarded from main_bus to SR1/SR2 in the same
// cycle (suppressed while rst is high).
module lc3_regfile_cc #(
  parameter int         NUM_REGS  = 8,
  parameter logic [2:0] RESET_NZP = 3'b010
) (
  input logic              clk,
  input logic              rst,
  lc3_regfile_cc_if.slave  bus
);

  // Condition codes for a bus value: exactly one of N, Z, P is set.
  function automatic logic [2:0] cc_of(input logic [15:0] v);
    logic [2:0] cc;
    if (v[15] == 1'b1) begin
      cc = 3'b100;
    end else if (v == 16'h0000) begin
      cc = 3'b010;
    end else begin
      cc = 3'b001;
    end
    return cc;
  endfunction

  logic [15:0] regs_r [NUM_REGS];
  logic [2:0]  nzp_r;
  logic        ben_r;
  logic [2:0]  sr1_idx_s;
  logic [2:0]  sr2_idx_s;
  logic [2:0]  dr_idx_s;
  logic        unused_ir_s;

  // Opcode and the middle operand field are decoded elsewhere.
  assign unused_ir_s = ^{bus.IR[15:12], bus.IR[5:3]};
  assign sr2_idx_s   = bus.IR[2:0];

  // SR1 source register select.
  always_comb begin
    sr1_idx_s = 3'd0;
    case (bus.SR1MUX)
      2'b00:   sr1_idx_s = bus.IR[11:9];
      2'b01:   sr1_idx_s = bus.IR[8:6];
      2'b10:   sr1_idx_s = 3'd6;
      2'b11:   sr1_idx_s = bus.IR[8:6];
      default: sr1_idx_s = 3'd0;
    endcase
  end

  // Destination register select (R7 for JSR/TRAP linkage, R6 for stack).
  always_comb begin
    dr_idx_s = 3'd0;
    case (bus.DRMUX)
      2'b00:   dr_idx_s = bus.IR[11:9];
      2'b01:   dr_idx_s = 3'd7;
      2'b10:   dr_idx_s = 3'd6;
      2'b11:   dr_idx_s = bus.IR[11:9];
      default: dr_idx_s = 3'd0;
    endcase
  end

  // Architectural state update; reset wins over every load strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= 16'h0000;
      end
      nzp_r <= RESET_NZP;
      ben_r <= 1'b0;
    end else begin
      if (bus.LD_REG) begin
        regs_r[dr_idx_s] <= bus.main_bus;
      end
      if (bus.LD_CC) begin
        nzp_r <= cc_of(bus.main_bus);
      end
      // BEN deliberately samples the pre-edge NZP, even alongside LD_CC.
      if (bus.LD_BEN) begin
        ben_r <= (bus.IR[11] & nzp_r[2]) |
                 (bus.IR[10] & nzp_r[1]) |
                 (bus.IR[9]  & nzp_r[0]);
      end
    end
  end

  // Operand read path, optionally forwarding the in-flight write.
  always_comb begin
    bus.SR1 = regs_r[sr1_idx_s];
    bus.SR2 = regs_r[sr2_idx_s];
`ifdef LC3_REGFILE_BYPASS_EN
    if (!rst && bus.LD_REG && (dr_idx_s == sr1_idx_s)) begin
      bus.SR1 = bus.main_bus;
    end else begin
      bus.SR1 = regs_r[sr1_idx_s];
    end
    if (!rst && bus.LD_REG && (dr_idx_s == sr2_idx_s)) begin
      bus.SR2 = bus.main_bus;
    end else begin
      bus.SR2 = regs_r[sr2_idx_s];
    end
`else
    bus.SR1 = regs_r[sr1_idx_s];
    bus.SR2 = regs_r[sr2_idx_s];
`endif
  end

  assign bus.NZP = nzp_r;
  assign bus.BEN = ben_r;

endmodule

// File: tb/tb_lc3_regfile_cc.sv
// tb_lc3_regfile_cc: directed stimulus with a queue-based scoreboard. The
// stimulus process drives inputs just after a rising edge and pushes the
// expected outputs for that cycle; the monitor pops and compares at the
// following falling edge.
module tb_lc3_regfile_cc;

  typedef struct {
    string       name;
    int          sel;   // 0=SR1 1=SR2 2=NZP 3=BEN
    logic [15:0] val;
  } exp_t;

  logic clk;
  logic rst;
  lc3_regfile_cc_if bus ();

  exp_t exp_q[$];
  int   checks;
  int   failures;

  lc3_regfile_cc #(.NUM_REGS(8), .RESET_NZP(3'b010)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: compare every pending expectation mid-cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] act;
    if ((bus.LD_REG || bus.LD_CC) && $isunknown(bus.main_bus)) begin
      failures++;
      $display("FAIL bus_undriven: main_bus=%h while a load strobe is set", bus.main_bus);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.sel)
        0:       act = bus.SR1;
        1:       act = bus.SR2;
        2:       act = {13'd0, bus.NZP};
        3:       act = {15'd0, bus.BEN};
        default: act = 16'hxxxx;
      endcase
      checks++;
      if (act !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.val, $time);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int sel, input logic [15:0] val, input string name);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  function automatic logic [15:0] mk_ir(input logic [2:0] f11, input logic [2:0] f8,
                                        input logic [2:0] f2);
    return {4'b0001, f11, f8, 3'b000, f2};
  endfunction

  task automatic idle();
    bus.LD_REG = 1'b0;
    bus.LD_CC  = 1'b0;
    bus.LD_BEN = 1'b0;
  endtask

  task automatic sweep_all(input logic [15:0] r3_val, input string name);
    for (int i = 0; i < 8; i++) begin
      bus.SR1MUX = 2'b00;
      bus.IR     = mk_ir(i[2:0], 3'd0, i[2:0]);
      expect_out(0, (i == 3) ? r3_val : 16'h0000, name);
      expect_out(1, (i == 3) ? r3_val : 16'h0000, name);
      cyc();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.IR = 16'h0000;
    bus.main_bus = 16'h0000;
    bus.SR1MUX = 2'b00;
    bus.DRMUX = 2'b00;
    idle();
    cyc();
    cyc();

    // 1: reset state
    rst = 1'b0;
    expect_out(2, 16'h0002, "reset_nzp");
    expect_out(3, 16'h0000, "reset_ben");
    sweep_all(16'h0000, "reset_regs");

    // 2: write R3 via IR[11:9], read back through SR2 and SR1
    bus.IR = mk_ir(3'd3, 3'd0, 3'd0);
    bus.DRMUX = 2'b00;
    bus.main_bus = 16'h1234;
    bus.LD_REG = 1'b1;
    cyc();
    idle();
    sweep_all(16'h1234, "write_r3");

    // 3: condition codes
    bus.LD_CC = 1'b1;
    bus.main_bus = 16'h8000;
    cyc();
    expect_out(2, 16'h0004, "cc_neg");
    bus.main_bus = 16'h0000;
    cyc();
    expect_out(2, 16'h0002, "cc_zero");
    bus.main_bus = 16'h7FFF;
    cyc();
    expect_out(2, 16'h0001, "cc_pos");
    idle();

    // 4: branch enable
    bus.IR = mk_ir(3'b001, 3'd0, 3'd0);
    bus.LD_BEN = 1'b1;
    cyc();
    expect_out(3, 16'h0001, "ben_p_match");
    bus.IR = mk_ir(3'b110, 3'd0, 3'd0);
    cyc();
    expect_out(3, 16'h0000, "ben_nz_nomatch");
    bus.IR = mk_ir(3'b010, 3'd0, 3'd0);
    bus.LD_CC = 1'b1;
    bus.main_bus = 16'h0000;
    cyc();
    expect_out(3, 16'h0000, "ben_old_nzp");
    expect_out(2, 16'h0002, "cc_with_ben");
    bus.LD_CC = 1'b0;
    cyc();
    expect_out(3, 16'h0001, "ben_z_match");
    idle();

    // 5: R7/R6 destinations, alternate SR1 selects, reset over strobes
    bus.DRMUX = 2'b01;
    bus.main_bus = 16'h3001;
    bus.LD_REG = 1'b1;
    cyc();
    idle();
    bus.SR1MUX = 2'b10;
    expect_out(0, 16'h0000, "r6_unchanged");
    cyc();
    bus.SR1MUX = 2'b00;
    bus.IR = mk_ir(3'd7, 3'd0, 3'd7);
    expect_out(0, 16'h3001, "r7_sr1");
    expect_out(1, 16'h3001, "r7_sr2");
    bus.DRMUX = 2'b10;
    bus.main_bus = 16'h6666;
    bus.LD_REG = 1'b1;
    cyc();
    idle();
    bus.SR1MUX = 2'b10;
    expect_out(0, 16'h6666, "r6_written");
    bus.IR = mk_ir(3'd5, 3'd0, 3'd0);
    bus.DRMUX = 2'b11;
    bus.main_bus = 16'h5555;
    bus.LD_REG = 1'b1;
    cyc();
    idle();
    bus.IR = mk_ir(3'd0, 3'd5, 3'd0);
    bus.SR1MUX = 2'b11;
    expect_out(0, 16'h5555, "sr1mux11_r5");
    cyc();
    bus.IR = mk_ir(3'd0, 3'd3, 3'd0);
    bus.SR1MUX = 2'b01;
    expect_out(0, 16'h1234, "sr1mux01_r3");
    cyc();
    rst = 1'b1;
    bus.IR = mk_ir(3'd3, 3'd0, 3'd0);
    bus.DRMUX = 2'b00;
    bus.main_bus = 16'hFFFF;
    bus.LD_REG = 1'b1;
    bus.LD_CC = 1'b1;
    bus.LD_BEN = 1'b1;
    cyc();
    rst = 1'b0;
    idle();
    expect_out(2, 16'h0002, "rst_over_cc");
    expect_out(3, 16'h0000, "rst_over_ben");
    sweep_all(16'h0000, "rst_over_reg");
    bus.SR1MUX = 2'b10;
    expect_out(0, 16'h0000, "rst_r6");
    cyc();

    // 6: same-cycle write/read of R2
    bus.SR1MUX = 2'b00;
    bus.IR = mk_ir(3'd2, 3'd0, 3'd2);
    bus.DRMUX = 2'b00;
    bus.main_bus = 16'hBEEF;
    bus.LD_REG = 1'b1;
`ifdef LC3_REGFILE_BYPASS_EN
    expect_out(0, 16'hBEEF, "bypass_sr1");
    expect_out(1, 16'hBEEF, "bypass_sr2");
`else
    expect_out(0, 16'h0000, "nobypass_sr1");
    expect_out(1, 16'h0000, "nobypass_sr2");
`endif
    cyc();
    idle();
    expect_out(0, 16'hBEEF, "r2_next_sr1");
    expect_out(1, 16'hBEEF, "r2_next_sr2");
    cyc();
    rst = 1'b1;
    bus.main_bus = 16'h1111;
    bus.LD_REG = 1'b1;
    expect_out(0, 16'hBEEF, "rst_no_bypass");
    cyc();
    rst = 1'b0;
    idle();
    expect_out(0, 16'h0000, "r2_after_rst");
    cyc();
    cyc();

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lc3_regfile_cc.md
Name: lc3_regfile_cc

Overview:
- Architectural state stage that directly feeds the LC-3 ALU and consumes its bus output.
- Holds the eight 16-bit general-purpose registers R0-R7 and supplies the SR1/SR2 operands.
- Writes the register file from main_bus.
- Holds the NZP condition codes and the BEN (branch enable) flag used by the control FSM.

Parameters:
- NUM_REGS, 8, number of general-purpose registers. Fixed at 8 for LC-3; register selects are 3 bits wide.
- RESET_NZP, 3'b010, NZP value loaded on reset (Z set).

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- IR  input  16  current instruction register
- main_bus  input  16  shared datapath bus (write data and CC source)
- SR1MUX  input  2  SR1 select: 00=IR[11:9], 01=IR[8:6], 10=R6, 11=IR[8:6]
- DRMUX  input  2  destination select: 00=IR[11:9], 01=R7, 10=R6, 11=IR[11:9]
- LD_REG  input  1  write main_bus into the selected destination register
- LD_CC  input  1  update NZP from main_bus
- LD_BEN  input  1  update BEN
- SR1  output  16  operand 1, equal to R[SR1 select]
- SR2  output  16  operand 2, equal to R[IR[2:0]]
- NZP  output  3  condition codes {N,Z,P}
- BEN  output  1  branch enable

Behaviour:
Interface:
- One clock; reset is synchronous and active-high. Ports are named clk and rst.
- All state changes occur on the rising edge of clk only.

Reset (rst=1 at a rising edge):
- R0-R7 <= 16'h0000; NZP <= RESET_NZP (3'b010); BEN <= 0.
- Reset overrides every load strobe in the same cycle.
- Reset asserted mid-sequence discards any pending writes.
- After reset, SR1=SR2=16'h0000.

Read path:
- SR1 and SR2 are combinational from register contents and selects; zero-cycle latency.

Write path (rst=0, LD_REG=1):
- R[DR] <= main_bus at the edge.
- The new value is visible on SR1/SR2 from the next cycle (see Optional Feature for same-cycle bypass).
- LD_REG=0 leaves all registers unchanged.

Condition codes (rst=0, LD_CC=1), with NZP latched at the edge:
- main_bus[15]=1 gives 3'b100.
- main_bus==16'h0000 gives 3'b010.
- Any other value gives 3'b001.
- Exactly one bit of NZP is set at all times.

Branch enable (rst=0, LD_BEN=1):
- BEN <= (IR[11]&N) | (IR[10]&Z) | (IR[9]&P), using the registered NZP value before the edge.
- If LD_CC and LD_BEN assert in the same cycle, BEN uses the old NZP.

Simultaneous strobes:
- LD_REG, LD_CC and LD_BEN are independent; any combination is legal in one cycle.
- LD_REG and LD_CC together write the register and set CC from the same bus value.

Undriven bus:
- Asserting LD_REG or LD_CC while main_bus is undriven (Z/X) is a control error.
- The stored value is unspecified; the bench asserts that this never occurs.

Optional Feature:
- Macro: LC3_REGFILE_BYPASS_EN.
- Defined: when LD_REG=1 and the destination index equals the SR1 index (or IR[2:0] for SR2), that output shows main_bus combinationally in the same cycle (write-through forwarding). Reset suppresses the bypass.
- Undefined: outputs always reflect the stored register contents; the written value appears the cycle after the edge.

Test Plan:
1. Reset, then read all eight registers via SR1MUX=00 while sweeping IR[11:9] -> SR1=16'h0000 for each; NZP=3'b010; BEN=0.
2. Bus=16'h1234, DRMUX=00, IR[11:9]=3, LD_REG=1 for one cycle; next cycle IR[2:0]=3 -> SR2=16'h1234; all other registers remain 0.
3. LD_CC with bus=16'h8000, then 16'h0000, then 16'h7FFF -> NZP=100, then 010, then 001, each in the cycle after its edge.
4. NZP=001; IR[11:9]=3'b001 and LD_BEN=1 -> BEN=1. Then IR[11:9]=3'b110 and LD_BEN=1 -> BEN=0. Then LD_CC with bus=0 and LD_BEN with IR[11:9]=010 in the same cycle -> BEN=0 (old NZP used); NZP=010.
5. DRMUX=01 with bus=16'h3001 and LD_REG=1; then SR1MUX=10 -> SR1 shows R6 (unchanged); R7 reads back 16'h3001. Then rst=1 together with LD_REG=1 and bus=16'hFFFF -> all registers 0; NZP=010.
6. (Macro defined) LD_REG=1, DR=R2, bus=16'hBEEF, SR1MUX selecting R2 -> SR1=16'hBEEF in the same cycle. (Macro undefined) -> SR1 shows the old value, then 16'hBEEF the next cycle.
